// File: rtl/noc_pkg.sv
// noc_pkg: flit field widths for the default 3x3 mesh, flit header layout and node-to-mesh coordinate helper
package noc_pkg;
  localparam int FC = (32 + 8 - 1) / 8;
  localparam int CW = (FC > 1) ? $clog2(FC) : 1;
  localparam int NW = $clog2(9);
  localparam int XW = $clog2(3);
  localparam int YW = $clog2(3);
  localparam int FLIT_W = 1 + XW + YW + 8 + 5 + NW + CW;
  typedef struct packed {
    logic          head;
    logic [XW-1:0] dest_x;
    logic [YW-1:0] dest_y;
    logic [7:0]    payload;
    logic [4:0]    id;
    logic [NW-1:0] src;
    logic [CW-1:0] idx;
  } flit_t;
  function automatic logic [15:0] node_to_xy(input int node, input int xdim);
    return {8'(node % xdim), 8'(node / xdim)};
  endfunction
endpackage

// File: rtl/noc_pkt_fifo.sv
// noc_pkt_fifo: per-channel packet queue; ports clk/rst_n/ce, push+din, pop, head (oldest), nxt (second oldest), count, empty, full
module noc_pkt_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [W-1:0] nxt,
  output logic [AW:0]  count,
  output logic         empty,
  output logic         full
);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else if (ce) begin
      if (push) wp <= wp + (AW+1)'(1);
      if (pop) rp <= rp + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (ce && push) mem[wp[AW-1:0]] <= din;
  assign head = mem[rp[AW-1:0]];
  assign nxt = mem[rp[AW-1:0] + AW'(1)];
  assign count = wp - rp;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
endmodule

// File: rtl/noc_flit_splitter_mc.sv
// noc_flit_splitter_mc: multi-channel packet queues, round-robin grant, serialised flit output
// ports: clk, rst_n (async, active-low), ce; per-channel in_valid/in_ready/in_data/in_dest/in_id/in_len;
//        flit_data/flit_valid/flit_ready/flit_last/flit_chan toward the router; err_drop pulse for bad destinations
module noc_flit_splitter_mc
  import noc_pkg::node_to_xy;
#(
  parameter int NODE_ID = 0,
  parameter int X = 3,
  parameter int Y = 3,
  parameter int CHANNELS = 2,
  parameter int QUEUE_DEPTH = 8,
  parameter int PAYLOAD = 32,
  parameter int FLIT_PAYLOAD = 8,
  parameter int PACKET_ID_WIDTH = 5,
  localparam int NN = X * Y,
  localparam int FC = (PAYLOAD + FLIT_PAYLOAD - 1) / FLIT_PAYLOAD,
  localparam int CW = (FC > 1) ? $clog2(FC) : 1,
  localparam int NW = $clog2(NN),
  localparam int XW = $clog2(X),
  localparam int YW = $clog2(Y),
  localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int FLIT_W = 1 + XW + YW + FLIT_PAYLOAD + PACKET_ID_WIDTH + NW + CW
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  ce,
  input  logic [CHANNELS-1:0]                   in_valid,
  output logic [CHANNELS-1:0]                   in_ready,
  input  logic [CHANNELS*PAYLOAD-1:0]           in_data,
  input  logic [CHANNELS*NW-1:0]                in_dest,
  input  logic [CHANNELS*PACKET_ID_WIDTH-1:0]   in_id,
  input  logic [CHANNELS*CW-1:0]                in_len,
  output logic [FLIT_W-1:0]                     flit_data,
  output logic                                  flit_valid,
  input  logic                                  flit_ready,
  output logic                                  flit_last,
  output logic [CHW-1:0]                        flit_chan,
  output logic                                  err_drop
);
  localparam int HW = PAYLOAD + XW + YW + PACKET_ID_WIDTH + CW;
  localparam int PW = FC * FLIT_PAYLOAD;
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int OY = CW + PACKET_ID_WIDTH;
  localparam int OX = OY + YW;
  localparam int OP = OX + XW;
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_n;
  logic [HW-1:0] din [CHANNELS];
  logic [HW-1:0] head [CHANNELS];
  logic [HW-1:0] nxt [CHANNELS];
  logic [HW-1:0] cand [CHANNELS];
  logic [AW:0] cnt [CHANNELS];
  logic [CHANNELS-1:0] push, drop, empty, full, pop, avail;
  logic [CHW-1:0] rr_ptr, pick, sel_ch, base, cand_ch;
  logic [CW-1:0] idx, sel_idx;
  logic [HW-1:0] hd, cur;
  logic [PW-1:0] pad;
  logic [FLIT_W-1:0] fd;
  logic fv, any, hs, last_hs, load_new, load_next;
  assign in_ready = {CHANNELS{rst_n & ce}} & ~full;
  assign flit_valid = fv & ce;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [NW-1:0] dest;
    logic [CW-1:0] l;
    logic ok;
    assign dest = in_dest[c*NW +: NW];
    assign l = in_len[c*CW +: CW];
    assign ok = int'(dest) < NN;
    assign push[c] = in_valid[c] & in_ready[c] & ok;
    assign drop[c] = in_valid[c] & in_ready[c] & !ok;
    assign din[c] = {in_data[c*PAYLOAD +: PAYLOAD], XW'(node_to_xy(int'(dest), X) >> 8),
                     YW'(node_to_xy(int'(dest), X)), in_id[c*PACKET_ID_WIDTH +: PACKET_ID_WIDTH],
                     (l > CW'(FC - 1)) ? CW'(FC - 1) : l};
    noc_pkt_fifo #(.W(HW), .DEPTH(QUEUE_DEPTH)) u_fifo (
      .clk(clk), .rst_n(rst_n), .ce(ce), .push(push[c]), .din(din[c]), .pop(pop[c]),
      .head(head[c]), .nxt(nxt[c]), .count(cnt[c]), .empty(empty[c]), .full(full[c])
    );
  end
  // During a last-flit handshake the granted queue is about to pop, so its candidate is
  // the entry behind the head (or the packet arriving this cycle); other queues offer
  // their head, or the arriving packet when empty, so flit 0 leaves the cycle after accept.
  always_comb begin
    cur = head[flit_chan];
    hs = fv & flit_ready;
    last_hs = state == SEND && hs && idx == cur[CW-1:0];
    load_next = state == SEND && hs && idx != cur[CW-1:0];
    pop = last_hs ? CHANNELS'(1) << flit_chan : '0;
    avail = '0;
    cand = '{default: '0};
    for (int i = 0; i < CHANNELS; i++) begin
      avail[i] = (state == SEND && flit_chan == CHW'(i)) ? (cnt[i] > (AW+1)'(1)) | push[i] : !empty[i] | push[i];
      cand[i] = (state == SEND && flit_chan == CHW'(i)) ? ((cnt[i] > (AW+1)'(1)) ? nxt[i] : din[i])
                                                        : (empty[i] ? din[i] : head[i]);
    end
    base = state == SEND ? flit_chan : rr_ptr;
    cand_ch = '0;
    pick = '0;
    any = 1'b0;
    for (int k = CHANNELS; k >= 1; k--) begin
      cand_ch = CHW'((int'(base) + k) % CHANNELS);
      if (avail[cand_ch]) begin
        pick = cand_ch;
        any = 1'b1;
      end
    end
    load_new = any && (state == IDLE || last_hs);
    sel_ch = load_new ? pick : flit_chan;
    sel_idx = load_new ? '0 : idx + CW'(1);
    hd = load_new ? cand[pick] : cur;
    pad = PW'(hd[OP +: PAYLOAD]);
    fd = {1'b1, hd[OX +: XW], hd[OY +: YW], pad[int'(sel_idx)*FLIT_PAYLOAD +: FLIT_PAYLOAD],
          hd[CW +: PACKET_ID_WIDTH], NW'(NODE_ID), sel_idx};
    state_n = (load_new || load_next) ? SEND : last_hs ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      idx <= '0;
      fv <= 1'b0;
      flit_data <= '0;
      flit_last <= 1'b0;
      flit_chan <= '0;
      err_drop <= 1'b0;
    end else if (ce) begin
      state <= state_n;
      err_drop <= |drop;
      fv <= load_new || load_next || (fv && !last_hs);
      if (last_hs) rr_ptr <= flit_chan;
      if (load_new || load_next) begin
        idx <= sel_idx;
        flit_data <= fd;
        flit_last <= sel_idx == hd[CW-1:0];
        flit_chan <= sel_ch;
      end
    end
endmodule
